// File: rtl/ram_2r1w_req_arbiter.sv
// rtl/ram_2r1w_req_arbiter.sv - one write and two read request channels arbitrated onto a 2R1W RAM
// Registered command stage, starvation-bounded write priority, per-port 2-entry response FIFOs.
module ram_2r1w_req_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [NUM_WMASKS-1:0]   w_wmask,
  input  logic [1:0]              r_valid,
  output logic [1:0]              r_ready,
  input  logic [2*ADDR_WIDTH-1:0] r_addr,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    ram_csb,
  output logic                    ram_web,
  output logic [NUM_WMASKS-1:0]   ram_wmask,
  output logic [2*ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [2*DATA_WIDTH-1:0] ram_dout
);

  logic                  blocked_q;
  logic [3:0]            starve_q;
  logic [READ_LAT:0]     pipe_valid;
  logic [1:0]            pipe_mask [READ_LAT+1];
  logic [DATA_WIDTH-1:0] fifo_mem [2][2];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            occ [2];

  logic [1:0]              eligible;
  logic [2:0]              in_flight;
  logic                    any_eligible;
  logic                    starve_hit;
  logic                    block;
  logic                    grant_write;
  logic                    grant_read;
  logic [2*ADDR_WIDTH-1:0] read_addr;
  logic [1:0]              push;
  logic [1:0]              pop;

  // A port may only issue while its reads in flight plus buffered responses leave FIFO room.
  always_comb begin
    eligible  = '0;
    in_flight = '0;
    for (int p = 0; p < 2; p++) begin
      in_flight = '0;
      for (int k = 0; k <= READ_LAT; k++) begin
        if (pipe_valid[k] && pipe_mask[k][p]) in_flight = in_flight + 3'd1;
      end
      eligible[p] = r_valid[p] && ((in_flight + {1'b0, occ[p]}) < 3'd2);
    end
  end

  always_comb begin
    block        = rst | blocked_q;
    any_eligible = |eligible;
    starve_hit   = (starve_q == 4'(STARVE_MAX));
    grant_write  = !block && w_valid && !(starve_hit && any_eligible);
    grant_read   = !block && !grant_write && any_eligible;
    w_ready      = grant_write;
    r_ready      = grant_read ? eligible : 2'b00;
    read_addr    = '0;
    for (int p = 0; p < 2; p++) begin
      if (r_ready[p]) read_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = r_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    blocked_q <= rst;
    if (rst || !(grant_write || grant_read)) begin
      ram_csb   <= 1'b1;
      ram_web   <= 1'b1;
      ram_wmask <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else if (grant_write) begin
      ram_csb   <= 1'b0;
      ram_web   <= 1'b0;
      ram_wmask <= w_wmask;
      ram_addr  <= {w_addr, w_addr};
      ram_din   <= w_data;
    end else begin
      ram_csb   <= 1'b0;
      ram_web   <= 1'b1;
      ram_wmask <= '0;
      ram_addr  <= read_addr;
      ram_din   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || grant_read || !any_eligible) begin
      starve_q <= '0;
    end else if (grant_write && !starve_hit) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_valid <= '0;
    else     pipe_valid <= {pipe_valid[READ_LAT-1:0], grant_read};
  end

  always_ff @(posedge clk) begin
    pipe_mask[0] <= r_ready;
    for (int k = 1; k <= READ_LAT; k++) pipe_mask[k] <= pipe_mask[k-1];
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int p = 0; p < 2; p++) begin
      push[p] = pipe_valid[READ_LAT] && pipe_mask[READ_LAT][p];
      pop[p]  = rsp_valid[p] && rsp_ready[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ[0] <= '0;
      occ[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wr_ptr[p] <= ~wr_ptr[p];
        if (pop[p])  rd_ptr[p] <= ~rd_ptr[p];
        if (push[p] && !pop[p])      occ[p] <= occ[p] + 2'd1;
        else if (pop[p] && !push[p]) occ[p] <= occ[p] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) fifo_mem[p][wr_ptr[p]] <= ram_dout[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int p = 0; p < 2; p++) begin
      rsp_valid[p] = (occ[p] != 2'd0);
      if (rsp_valid[p]) rsp_data[p*DATA_WIDTH +: DATA_WIDTH] = fifo_mem[p][rd_ptr[p]];
    end
  end

endmodule

// File: tb/tb_ram_2r1w_req_arbiter.sv
// tb/tb_ram_2r1w_req_arbiter.sv - directed vector bench for ram_2r1w_req_arbiter
// Includes a behavioural 256x32 2R1W RAM with one-edge read latency.
module tb_ram_2r1w_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid;
  logic        w_ready;
  logic [7:0]  w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_wmask;
  logic [1:0]  r_valid;
  logic [1:0]  r_ready;
  logic [15:0] r_addr;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic        ram_csb;
  logic        ram_web;
  logic [3:0]  ram_wmask;
  logic [15:0] ram_addr;
  logic [31:0] ram_din;
  logic [63:0] ram_dout;

  int errors = 0;
  int checks = 0;

  ram_2r1w_req_arbiter dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_wmask(w_wmask),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_csb(ram_csb), .ram_web(ram_web), .ram_wmask(ram_wmask), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ram_dout = '0;
  end

  always @(posedge clk) begin
    if (!ram_csb) begin
      if (!ram_web) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= {mem[ram_addr[15:8]], mem[ram_addr[7:0]]};
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wv;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [1:0]  rv;
    logic [15:0] ra;
    logic        e_wr;
    logic [1:0]  e_rr;
    logic        e_csb;
    logic        e_web;
    logic [15:0] e_addr;
    logic [31:0] e_din;
    logic [3:0]  e_mask;
    logic [1:0]  e_rspv;
    logic [63:0] e_rspd;
  } vec_t;

  vec_t vecs [12];

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    w_valid = v.wv; w_addr = v.wa; w_data = v.wd; w_wmask = v.wm;
    r_valid = v.rv; r_addr = v.ra;
    #1;
    chk($sformatf("v%0d w_ready", idx), 64'(w_ready), 64'(v.e_wr));
    chk($sformatf("v%0d r_ready", idx), 64'(r_ready), 64'(v.e_rr));
    @(posedge clk); #1;
    w_valid = 1'b0; r_valid = 2'b00;
    chk($sformatf("v%0d ram_csb", idx), 64'(ram_csb), 64'(v.e_csb));
    chk($sformatf("v%0d ram_web", idx), 64'(ram_web), 64'(v.e_web));
    chk($sformatf("v%0d ram_addr", idx), 64'(ram_addr), 64'(v.e_addr));
    chk($sformatf("v%0d ram_din", idx), 64'(ram_din), 64'(v.e_din));
    chk($sformatf("v%0d ram_wmask", idx), 64'(ram_wmask), 64'(v.e_mask));
    @(posedge clk); #1;
    chk($sformatf("v%0d rsp_valid early", idx), 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d rsp_valid", idx), 64'(rsp_valid), 64'(v.e_rspv));
    chk($sformatf("v%0d rsp_data", idx), rsp_data, v.e_rspd);
    idle(2);
  endtask

  logic [31:0] exp_q [$];
  int          got;

  initial begin
    vecs[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h1010, 32'hDEADBEEF, 4'hF, 2'b00, 64'h0};
    vecs[1]  = '{1'b0, 8'h00, 32'h0, 4'h0, 2'b01, 16'h0010, 1'b0, 2'b01, 1'b0, 1'b1, 16'h0010, 32'h0, 4'h0, 2'b01, 64'h00000000_DEADBEEF};
    vecs[2]  = '{1'b1, 8'h20, 32'h11223344, 4'hF, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h2020, 32'h11223344, 4'hF, 2'b00, 64'h0};
    vecs[3]  = '{1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h2020, 32'hAABBCCDD, 4'h5, 2'b00, 64'h0};
    vecs[4]  = '{1'b0, 8'h00, 32'h0, 4'h0, 2'b10, 16'h2000, 1'b0, 2'b10, 1'b0, 1'b1, 16'h2000, 32'h0, 4'h0, 2'b10, 64'h11BB33DD_00000000};
    vecs[5]  = '{1'b1, 8'h01, 32'h01010101, 4'hF, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0101, 32'h01010101, 4'hF, 2'b00, 64'h0};
    vecs[6]  = '{1'b1, 8'h02, 32'h02020202, 4'hF, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0202, 32'h02020202, 4'hF, 2'b00, 64'h0};
    vecs[7]  = '{1'b0, 8'h00, 32'h0, 4'h0, 2'b11, 16'h0201, 1'b0, 2'b11, 1'b0, 1'b1, 16'h0201, 32'h0, 4'h0, 2'b11, 64'h02020202_01010101};
    vecs[8]  = '{1'b1, 8'h30, 32'hCAFEF00D, 4'h3, 2'b01, 16'h0010, 1'b1, 2'b00, 1'b0, 1'b0, 16'h3030, 32'hCAFEF00D, 4'h3, 2'b00, 64'h0};
    vecs[9]  = '{1'b0, 8'h00, 32'h0, 4'h0, 2'b01, 16'h0030, 1'b0, 2'b01, 1'b0, 1'b1, 16'h0030, 32'h0, 4'h0, 2'b01, 64'h00000000_0000F00D};
    vecs[10] = '{1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h1010, 32'hFFFFFFFF, 4'h0, 2'b00, 64'h0};
    vecs[11] = '{1'b0, 8'h00, 32'h0, 4'h0, 2'b01, 16'h0010, 1'b0, 2'b01, 1'b0, 1'b1, 16'h0010, 32'h0, 4'h0, 2'b01, 64'h00000000_DEADBEEF};

    // Reset with every request asserted; nothing may be granted during or right after it.
    rst = 1'b1; w_valid = 1'b1; w_addr = 8'h77; w_data = 32'h12345678; w_wmask = 4'hF;
    r_valid = 2'b11; r_addr = 16'h0102; rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst w_ready", 64'(w_ready), 64'd0);
    chk("rst r_ready", 64'(r_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_data", rsp_data, 64'd0);
    chk("rst ram_csb", 64'(ram_csb), 64'd1);
    chk("rst ram_web", 64'(ram_web), 64'd1);
    chk("rst ram_addr", 64'(ram_addr), 64'd0);
    chk("rst ram_din", 64'(ram_din), 64'd0);
    chk("rst ram_wmask", 64'(ram_wmask), 64'd0);
    rst = 1'b0; #1;
    chk("post-rst w_ready", 64'(w_ready), 64'd0);
    chk("post-rst r_ready", 64'(r_ready), 64'd0);
    @(posedge clk); #1;
    chk("post-rst ram_csb", 64'(ram_csb), 64'd1);
    @(negedge clk); #1;
    chk("recovered w_ready", 64'(w_ready), 64'd1);
    w_valid = 1'b0; r_valid = 2'b00;
    idle(3);

    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);
    idle(3);

    // Writes held against a waiting read: four writes, one read, repeat.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      w_valid = 1'b1; w_addr = 8'h50; w_data = 32'(i); w_wmask = 4'hF;
      r_valid = 2'b01; r_addr = 16'h0010;
      #1;
      chk($sformatf("starve cycle %0d grant", i), {61'd0, w_ready, r_ready},
          (i == 4 || i == 9) ? 64'b001 : 64'b100);
    end
    @(negedge clk);
    w_valid = 1'b0; r_valid = 2'b00;
    idle(6);

    // Port 0 backpressure: two reads fill the FIFO, the third waits for a pop.
    rsp_ready = 2'b10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r_valid = 2'b01;
      r_addr = (i == 0) ? 16'h0001 : (i == 1) ? 16'h0002 : 16'h0003;
      #1;
      chk($sformatf("bp cycle %0d r_ready", i), 64'(r_ready[0]), (i < 2) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    r_addr = 16'h0010; rsp_ready = 2'b11; #1;
    chk("bp full r_ready", 64'(r_ready[0]), 64'd0);
    chk("bp head 0", 64'(rsp_data[31:0]), 64'h01010101);
    @(negedge clk);
    rsp_ready = 2'b10; #1;
    chk("bp after pop r_ready", 64'(r_ready[0]), 64'd1);
    chk("bp head 1", 64'(rsp_data[31:0]), 64'h02020202);
    @(negedge clk);
    r_valid = 2'b00; rsp_ready = 2'b11;
    exp_q = '{32'h02020202, 32'hDEADBEEF};
    got = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid[0]) begin
        if (got < 2) chk($sformatf("bp drain %0d", got), 64'(rsp_data[31:0]), 64'(exp_q[got]));
        got++;
      end
      @(negedge clk);
    end
    chk("bp drain count", 64'(got), 64'd2);
    idle(2);

    // Reset one cycle after a read is accepted drops that read.
    @(negedge clk);
    r_valid = 2'b01; r_addr = 16'h0010; #1;
    chk("mid-rst read accepted", 64'(r_ready), 64'b01);
    @(negedge clk);
    r_valid = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("mid-rst ram_csb", 64'(ram_csb), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid-rst rsp_valid %0d", i), 64'(rsp_valid), 64'd0);
      @(negedge clk); #1;
    end
    apply_vec(vecs[11], 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_2r1w_req_arbiter.md
RAM_2R1W_REQ_ARBITER -- requirements
Module: ram_2r1w_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, byte-lane write mask width (DATA_WIDTH/8).
REQ-004 SHALL have parameter READ_LAT, default 1, RAM edges from command capture to valid dout; legal range 1..3.
REQ-005 SHALL have parameter STARVE_MAX, default 4, consecutive write grants tolerated while a read waits; legal range 1..15.
REQ-006 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports w_valid in 1, w_ready out 1, w_addr in ADDR_WIDTH, w_data in DATA_WIDTH, w_wmask in NUM_WMASKS: write request channel.
REQ-009 SHALL have ports r_valid in 2, r_ready out 2, r_addr in 2*ADDR_WIDTH: read request channels, port p in slice p.
REQ-010 SHALL have ports rsp_valid out 2, rsp_ready in 2, rsp_data out 2*DATA_WIDTH: read response channels, port p in slice p.
REQ-011 SHALL have ports ram_csb out 1, ram_web out 1, ram_wmask out NUM_WMASKS, ram_addr out 2*ADDR_WIDTH, ram_din out DATA_WIDTH, ram_dout in 2*DATA_WIDTH: drives the 256x32 2R1W RAM port 0 (csb/web active low).

Function
REQ-012 SHALL accept a request on any channel only when valid and ready are both high at a rising edge.
REQ-013 SHALL register the accepted operation into a command stage that drives all ram_* outputs during the following cycle; no combinational path from request inputs to ram_* outputs.
REQ-014 SHALL issue at most one RAM operation per cycle: WRITE, READ, or NOP.
REQ-015 WRITE command SHALL drive ram_csb=0, ram_web=0, ram_addr={w_addr,w_addr}, ram_din=w_data, ram_wmask=w_wmask.
REQ-016 READ command SHALL drive ram_csb=0, ram_web=1, ram_wmask=0, ram_addr slice p = r_addr slice p for each granted port, 0 for an ungranted port; both ports SHALL be granted in the same READ when both are eligible.
REQ-017 NOP SHALL drive ram_csb=1, ram_web=1, ram_addr=0, ram_din=0, ram_wmask=0.
REQ-018 A read port SHALL be eligible when r_valid[p]=1 and its in-flight count plus response-FIFO occupancy is below 2.
REQ-019 Arbitration SHALL grant WRITE when w_valid=1, unless the starve counter equals STARVE_MAX and some read port is eligible, in which case READ is granted.
REQ-020 Starve counter SHALL increment (saturating at STARVE_MAX) on each WRITE grant while any read port is eligible, and clear on any READ grant or when no read port is eligible.
REQ-021 r_ready[p] SHALL be high only in a cycle where READ is granted and port p is eligible; w_ready only where WRITE is granted.
REQ-022 SHALL track each READ in a READ_LAT+1-deep valid/port-mask shift pipeline and capture ram_dout slice p into port p's 2-entry response FIFO at rising edge N+1+READ_LAT for a read accepted at edge N.
REQ-023 rsp_valid[p] SHALL equal FIFO p non-empty; rsp_data slice p SHALL show FIFO head; head pops when rsp_valid[p] and rsp_ready[p] both high.
REQ-024 Simultaneous push and pop on a FIFO SHALL keep occupancy unchanged and preserve order; push into a full FIFO SHALL be impossible by REQ-018.
REQ-025 Operations SHALL reach the RAM in acceptance order; a read accepted after a write to the same address SHALL return the written data (masked lanes only updated).
REQ-026 Responses on each port SHALL return in request order; ports are independent.

Reset
REQ-027 While rst=1 at an edge: command stage set to NOP, read pipeline valid bits cleared (in-flight reads discarded), both FIFOs emptied, starve counter cleared.
REQ-028 Outputs during and in the cycle after reset: w_ready=0, r_ready=0, rsp_valid=0, rsp_data=0, ram_csb=1, ram_web=1, ram_addr=0, ram_din=0, ram_wmask=0.
REQ-029 Reset asserted mid-operation SHALL produce no rsp_valid for requests accepted before reset.

Verification
REQ-030 Write addr 0x10 data 0xDEADBEEF mask 0xF, then read port 0 addr 0x10 -> rsp_data[31:0]=0xDEADBEEF, rsp_valid[0] from edge N+2 (READ_LAT=1).
REQ-031 Write 0x11223344 mask 0xF then 0xAABBCCDD mask 0x5 to addr 0x20, read port 1 -> 0x11BB33DD.
REQ-032 Both ports read addr 0x01/0x02 in one cycle -> single ram_csb=0 cycle with ram_addr={0x02,0x01}; both responses in the same cycle.
REQ-033 w_valid held high, r_valid[0] high, STARVE_MAX=4 -> exactly 4 WRITE grants, then one READ, then writes resume.
REQ-034 rsp_ready[0]=0, r_valid[0] held -> exactly 2 reads accepted, r_ready[0] stays low until a pop; no data lost or reordered.
REQ-035 rst pulsed one cycle after a read is accepted -> no rsp_valid, ram_csb=1 next cycle, normal operation afterwards.
